// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_fifo #(
    parameter int CLK_BITS   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CLK_BITS-1:0]         clk_per_bit,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                push, pop, fifo_empty;

    state_e              state_q, state_d;
    logic [CLK_BITS-1:0] timer_q, timer_d;
    logic [CLK_BITS-1:0] period_q, period_d;
    logic [CLK_BITS-1:0] eff_per;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                start_frame;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    assign fifo_empty = (count_q == '0);
    assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
    assign push       = tx_valid & tx_ready;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign uart_tx    = tx_q;
    // Periods below 4 clocks are clamped so every bit is still observable.
    assign eff_per    = (clk_per_bit < CLK_BITS'(4)) ? CLK_BITS'(4) : clk_per_bit;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        period_d    = period_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = 1'b1;
        start_frame = 1'b0;
        pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) start_frame = 1'b1;
            end
            S_START: begin
                tx_d = 1'b0;
                if (timer_q == '0) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    timer_d = period_q - CLK_BITS'(1);
                end else begin
                    timer_d = timer_q - CLK_BITS'(1);
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (timer_q == '0) begin
                    timer_d = period_q - CLK_BITS'(1);
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_q == 3'd7) state_d = S_STOP;
`endif
                end else begin
                    timer_d = timer_q - CLK_BITS'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d = par_q;
                if (timer_q == '0) begin
                    state_d = S_STOP;
                    timer_d = period_q - CLK_BITS'(1);
                end else begin
                    timer_d = timer_q - CLK_BITS'(1);
                end
            end
`endif
            S_STOP: begin
                if (timer_q == '0) begin
                    if (!fifo_empty) start_frame = 1'b1;
                    else             state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q - CLK_BITS'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared by IDLE and the last STOP cycle so back-to-back frames have no gap.
        if (start_frame) begin
            pop      = 1'b1;
            state_d  = S_START;
            shift_d  = mem_q[rd_ptr_q];
            period_d = eff_per;
            timer_d  = eff_per - CLK_BITS'(1);
`ifdef UART_TX_PARITY_EN
            par_d    = ^mem_q[rd_ptr_q];
`endif
        end
    end

    // tx_q follows the state one cycle late, giving a registered, glitch-free line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            period_q <= CLK_BITS'(4);
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: framing, latency, FIFO fill/drop, mid-frame reset.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] clk_per_bit = 10'd16;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, uart_tx, busy;
    logic [2:0] fifo_count;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_fifo #(.CLK_BITS(10), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .clk_per_bit(clk_per_bit),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns at the negedge where the line is first seen low (current sample included).
    task automatic wait_start(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (uart_tx == 1'b0) return;
            @(negedge clk);
        end
        chk({tag, "_timeout"}, 32'(uart_tx), 32'd0);
    endtask

    // Called on the negedge holding the first start-bit sample; checks every cycle.
    task automatic expect_frame(input logic [7:0] b, input int per, input string tag);
        logic [10:0] bits;
        int nb;
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, ^b, b, 1'b0};
        nb   = 11;
`else
        bits = {1'b1, 1'b1, b, 1'b0};
        nb   = 10;
`endif
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < per; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                chk(tag, 32'(uart_tx), 32'(bits[k]));
            end
        end
    endtask

    task automatic push1(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] vals [6];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte, exact push -> pop -> start latency.
        clk_per_bit = 10'd16;
        push1(8'hA5);
        chk("lat_count1", 32'(fifo_count), 32'd1);
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_tx_n", 32'(uart_tx), 32'd1);
        @(negedge clk);
        chk("lat_count0", 32'(fifo_count), 32'd0);
        chk("lat_tx_n1", 32'(uart_tx), 32'd1);
        @(negedge clk);
        expect_frame(8'hA5, 16, "a5");
        chk("a5_busy_end", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // Three back-to-back frames, no idle gap.
        clk_per_bit = 10'd8;
        tx_valid = 1'b1;
        tx_data = 8'h00; @(negedge clk);
        tx_data = 8'hFF; @(negedge clk);
        tx_data = 8'h3C; @(negedge clk);
        tx_valid = 1'b0;
        wait_start(20, "b2b");
        expect_frame(8'h00, 8, "b2b_00");
        @(negedge clk);
        expect_frame(8'hFF, 8, "b2b_ff");
        @(negedge clk);
        expect_frame(8'h3C, 8, "b2b_3c");
        chk("b2b_busy_end", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // Period clamp: 2 -> 4.
        clk_per_bit = 10'd2;
        push1(8'h5A);
        wait_start(20, "clamp");
        expect_frame(8'h5A, 4, "clamp_5a");
        repeat (3) @(negedge clk);

        // Period change mid-frame is ignored until the next frame.
        clk_per_bit = 10'd16;
        push1(8'hC3);
        fork
            begin
                wait_start(20, "midchg");
                expect_frame(8'hC3, 16, "midchg_c3");
            end
            begin
                repeat (40) @(negedge clk);
                clk_per_bit = 10'd32;
            end
        join
        repeat (3) @(negedge clk);

        // Hold valid 6 cycles: 1 popped + 4 queued, 6th dropped, 5 frames.
        clk_per_bit = 10'd4;
        fork
            begin
                tx_valid = 1'b1;
                tx_data = vals[0];
                for (int i = 1; i < 6; i++) begin
                    @(negedge clk);
                    tx_data = vals[i];
                end
                @(negedge clk);
                tx_valid = 1'b0;
                chk("full_ready", 32'(tx_ready), 32'd0);
                chk("full_count", 32'(fifo_count), 32'd4);
            end
            begin
                wait_start(20, "full");
                for (int f = 0; f < 5; f++) begin
                    if (f != 0) @(negedge clk);
                    expect_frame(vals[f], 4, "full_frame");
                end
            end
        join
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("full_no6th", 32'(uart_tx), 32'd1);
        end
        chk("full_busy_end", 32'(busy), 32'd0);
        chk("full_count_end", 32'(fifo_count), 32'd0);

        // Reset during DATA bit 3 (F0: bit3 = 0) with a second byte queued.
        clk_per_bit = 10'd8;
        tx_valid = 1'b1;
        tx_data = 8'hF0; @(negedge clk);
        tx_data = 8'h0F; @(negedge clk);
        tx_valid = 1'b0;
        wait_start(20, "rst");
        repeat (34) @(negedge clk);
        chk("rst_pre_tx", 32'(uart_tx), 32'd0);
        chk("rst_pre_count", 32'(fifo_count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(uart_tx), 32'd1);
        chk("rst_mid_count", 32'(fifo_count), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("rst_post_idle", 32'(uart_tx), 32'd1);
        end
        chk("rst_post_busy", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // 0x07 has odd weight, so the even-parity bit is 1.
        clk_per_bit = 10'd10;
        push1(8'h07);
        wait_start(20, "par");
        expect_frame(8'h07, 10, "par_07");
        chk("par_busy_end", 32'(busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
